// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit.
package mc_pkg;

    localparam int N_STATE_W = 4;

    // Opcode field values
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Function field values for R-type
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Datapath select encodings
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;

    localparam logic [1:0] RDST_RT  = 2'b00;
    localparam logic [1:0] RDST_RD  = 2'b01;
    localparam logic [1:0] RDST_R31 = 2'b10;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_PC4   = 2'b10;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_J    = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    typedef enum logic [N_STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DCD    = 4'd1,
        S_EXE_R  = 4'd2,
        S_EXE_I  = 4'd3,
        S_WB_ALU = 4'd4,
        S_MADR   = 4'd5,
        S_MWR    = 4'd6,
        S_MRD    = 4'd7,
        S_MWB    = 4'd8,
        S_BR     = 4'd9,
        S_JMP    = 4'd10
    } state_e;

    // Instruction-class one-hots produced by the decoder
    typedef struct packed {
        logic is_r;
        logic is_ori;
        logic is_lui;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_j;
        logic is_jal;
        logic is_jr;
        logic is_illegal;
    } dec_t;

    // Complete control word driven towards the datapath
    typedef struct packed {
        logic       pcwr;
        logic       irwr;
        logic       regwr;
        logic       dmwr;
        logic       extop;
        logic       alusrc;
        logic [2:0] aluop;
        logic [1:0] regdst;
        logic [1:0] wbsel;
        logic [1:0] npcsel;
        logic       illegal;
    } ctl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control-unit bus: instruction fields and flag in, datapath controls out.
interface mc_ctrl_if;
    import mc_pkg::*;

    logic [5:0]           op;
    logic [5:0]           func;
    logic                 zero;
    logic                 pcwr;
    logic                 irwr;
    logic                 regwr;
    logic                 dmwr;
    logic                 extop;
    logic                 alusrc;
    logic [2:0]           aluop;
    logic [1:0]           regdst;
    logic [1:0]           wbsel;
    logic [1:0]           npcsel;
    logic                 illegal;
    logic [N_STATE_W-1:0] state;

    // Controller side
    modport master (
        input  op, func, zero,
        output pcwr, irwr, regwr, dmwr, extop, alusrc, aluop,
               regdst, wbsel, npcsel, illegal, state
    );

    // Datapath side
    modport slave (
        output op, func, zero,
        input  pcwr, irwr, regwr, dmwr, extop, alusrc, aluop,
               regdst, wbsel, npcsel, illegal, state
    );

endinterface

// File: rtl/mc_decode.sv
// Combinational op/func decoder into one-hot instruction classes.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output dec_t       dec_o
);

    // Map opcode/function to exactly one instruction class
    always_comb begin
        dec_o = '0;
        case (op_i)
            OP_RTYPE: begin
                case (func_i)
                    FN_ADDU, FN_SUBU: dec_o.is_r       = 1'b1;
                    FN_JR:            dec_o.is_jr      = 1'b1;
                    default:          dec_o.is_illegal = 1'b1;
                endcase
            end
            OP_ORI:  dec_o.is_ori     = 1'b1;
            OP_LUI:  dec_o.is_lui     = 1'b1;
            OP_LW:   dec_o.is_lw      = 1'b1;
            OP_SW:   dec_o.is_sw      = 1'b1;
            OP_BEQ:  dec_o.is_beq     = 1'b1;
            OP_J:    dec_o.is_j       = 1'b1;
            OP_JAL:  dec_o.is_jal     = 1'b1;
            default: dec_o.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    mc_ctrl_if.master bus
);

    state_e state_q;
    state_e state_d;
    dec_t   dec_s;
    ctl_t   ctl_s;

    mc_decode u_decode (
        .op_i   (bus.op),
        .func_i (bus.func),
        .dec_o  (dec_s)
    );

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DCD;
            S_DCD: begin
                if (dec_s.is_r) begin
                    state_d = S_EXE_R;
                end else if (dec_s.is_ori || dec_s.is_lui) begin
                    state_d = S_EXE_I;
                end else if (dec_s.is_lw || dec_s.is_sw) begin
                    state_d = S_MADR;
                end else if (dec_s.is_beq) begin
                    state_d = S_BR;
                end else if (dec_s.is_j || dec_s.is_jal || dec_s.is_jr) begin
                    state_d = S_JMP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXE_R:  state_d = S_WB_ALU;
            S_EXE_I:  state_d = S_WB_ALU;
            S_MADR:   state_d = dec_s.is_lw ? S_MRD : S_MWR;
            S_MRD:    state_d = S_MWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Control word per state; beq's PC write follows the zero flag directly
    always_comb begin
        ctl_s = '0;
        case (state_q)
            S_FETCH: begin
                ctl_s.pcwr   = 1'b1;
                ctl_s.irwr   = 1'b1;
                ctl_s.npcsel = NPC_PC4;
            end
            S_DCD: ctl_s.illegal = dec_s.is_illegal;
            S_EXE_R, S_EXE_I, S_WB_ALU: begin
                // Execute settings are repeated in writeback so the ALU result stays valid
                if (dec_s.is_r) begin
                    ctl_s.alusrc = 1'b0;
                    ctl_s.aluop  = (bus.func == FN_SUBU) ? ALU_SUB : ALU_ADD;
                    ctl_s.regdst = RDST_RD;
                end else begin
                    ctl_s.alusrc = 1'b1;
                    ctl_s.aluop  = dec_s.is_lui ? ALU_LUI : ALU_OR;
                    ctl_s.regdst = RDST_RT;
                end
                ctl_s.regwr = (state_q == S_WB_ALU);
                ctl_s.wbsel = WB_ALU;
            end
            S_MADR, S_MRD, S_MWR: begin
                ctl_s.alusrc = 1'b1;
                ctl_s.extop  = 1'b1;
                ctl_s.aluop  = ALU_ADD;
                ctl_s.dmwr   = (state_q == S_MWR);
            end
            S_MWB: begin
                ctl_s.regwr  = 1'b1;
                ctl_s.regdst = RDST_RT;
                ctl_s.wbsel  = WB_MEM;
            end
            S_BR: begin
                ctl_s.aluop  = ALU_SUB;
                ctl_s.alusrc = 1'b0;
                ctl_s.extop  = 1'b1;
                ctl_s.npcsel = NPC_BR;
                ctl_s.pcwr   = bus.zero;
            end
            S_JMP: begin
                ctl_s.pcwr = 1'b1;
                if (dec_s.is_jr) begin
                    ctl_s.npcsel = NPC_JR;
                end else if (dec_s.is_jal) begin
                    ctl_s.npcsel = NPC_J;
                    ctl_s.regwr  = 1'b1;
                    ctl_s.regdst = RDST_R31;
                    ctl_s.wbsel  = WB_PC4;
                end else begin
                    ctl_s.npcsel = NPC_J;
                end
            end
            default: ctl_s = '0;
        endcase
    end

    // While reset is held every control is quiet, even though FETCH would drive writes
    assign bus.pcwr    = rst_n & ctl_s.pcwr;
    assign bus.irwr    = rst_n & ctl_s.irwr;
    assign bus.regwr   = rst_n & ctl_s.regwr;
    assign bus.dmwr    = rst_n & ctl_s.dmwr;
    assign bus.extop   = rst_n & ctl_s.extop;
    assign bus.alusrc  = rst_n & ctl_s.alusrc;
    assign bus.aluop   = rst_n ? ctl_s.aluop  : 3'b000;
    assign bus.regdst  = rst_n ? ctl_s.regdst : 2'b00;
    assign bus.wbsel   = rst_n ? ctl_s.wbsel  : 2'b00;
    assign bus.npcsel  = rst_n ? ctl_s.npcsel : 2'b00;
    assign bus.illegal = rst_n & ctl_s.illegal;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed table, random instructions, reset abort.
module tb_mc_ctrl;
    import mc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q[$];

    typedef enum int {C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW,
                      C_BEQ, C_J, C_JAL, C_ILL} cls_e;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] func;
        logic       zero;
        int         cpi;
    } vec_t;

    vec_t tbl[12];

    // {state, pcwr, irwr, regwr, dmwr, extop, alusrc, aluop, regdst, wbsel, npcsel, illegal}
    function automatic logic [19:0] dut_vec();
        return {bus.state, bus.pcwr, bus.irwr, bus.regwr, bus.dmwr, bus.extop,
                bus.alusrc, bus.aluop, bus.regdst, bus.wbsel, bus.npcsel, bus.illegal};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] st, input bit pc, input bit ir, input bit rw,
                        input bit dw, input bit ex, input bit as, input logic [2:0] ao,
                        input logic [1:0] rd, input logic [1:0] wb, input logic [1:0] np,
                        input bit il);
        exp_q.push_back({st, pc, ir, rw, dw, ex, as, ao, rd, wb, np, il});
    endtask

    function automatic cls_e classify(input logic [5:0] op, input logic [5:0] func);
        case (op)
            6'b000000: begin
                if (func == 6'b100001) return C_ADDU;
                if (func == 6'b100011) return C_SUBU;
                if (func == 6'b001000) return C_JR;
                return C_ILL;
            end
            6'b001101: return C_ORI;
            6'b001111: return C_LUI;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic int cpi_of(input cls_e c);
        case (c)
            C_ADDU, C_SUBU, C_ORI, C_LUI, C_SW: return 4;
            C_LW:                               return 5;
            C_ILL:                              return 2;
            default:                            return 3;
        endcase
    endfunction

    // Expected cycle-by-cycle control words for one instruction
    task automatic model(input logic [5:0] op, input logic [5:0] func, input bit zero);
        cls_e c;
        c = classify(op, func);
        exp_q.delete();
        push(S_FETCH, 1, 1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 0);
        if (c == C_ILL) begin
            push(S_DCD, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 1);
        end else begin
            push(S_DCD, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 0);
            case (c)
                C_ADDU: begin
                    push(S_EXE_R,  0, 0, 0, 0, 0, 0, 3'b000, 2'b01, 2'b00, 2'b00, 0);
                    push(S_WB_ALU, 0, 0, 1, 0, 0, 0, 3'b000, 2'b01, 2'b00, 2'b00, 0);
                end
                C_SUBU: begin
                    push(S_EXE_R,  0, 0, 0, 0, 0, 0, 3'b001, 2'b01, 2'b00, 2'b00, 0);
                    push(S_WB_ALU, 0, 0, 1, 0, 0, 0, 3'b001, 2'b01, 2'b00, 2'b00, 0);
                end
                C_ORI: begin
                    push(S_EXE_I,  0, 0, 0, 0, 0, 1, 3'b010, 2'b00, 2'b00, 2'b00, 0);
                    push(S_WB_ALU, 0, 0, 1, 0, 0, 1, 3'b010, 2'b00, 2'b00, 2'b00, 0);
                end
                C_LUI: begin
                    push(S_EXE_I,  0, 0, 0, 0, 0, 1, 3'b011, 2'b00, 2'b00, 2'b00, 0);
                    push(S_WB_ALU, 0, 0, 1, 0, 0, 1, 3'b011, 2'b00, 2'b00, 2'b00, 0);
                end
                C_LW: begin
                    push(S_MADR, 0, 0, 0, 0, 1, 1, 3'b000, 2'b00, 2'b00, 2'b00, 0);
                    push(S_MRD,  0, 0, 0, 0, 1, 1, 3'b000, 2'b00, 2'b00, 2'b00, 0);
                    push(S_MWB,  0, 0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b01, 2'b00, 0);
                end
                C_SW: begin
                    push(S_MADR, 0, 0, 0, 0, 1, 1, 3'b000, 2'b00, 2'b00, 2'b00, 0);
                    push(S_MWR,  0, 0, 0, 1, 1, 1, 3'b000, 2'b00, 2'b00, 2'b00, 0);
                end
                C_BEQ: push(S_BR, zero, 0, 0, 0, 1, 0, 3'b001, 2'b00, 2'b00, 2'b01, 0);
                C_J:   push(S_JMP, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b10, 0);
                C_JAL: push(S_JMP, 1, 0, 1, 0, 0, 0, 3'b000, 2'b10, 2'b10, 2'b10, 0);
                default: push(S_JMP, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b11, 0);
            endcase
        end
    endtask

    // Run one instruction from FETCH; samples are taken 1 time unit after the falling edge
    task automatic run(input string name, input logic [5:0] op, input logic [5:0] func,
                       input bit zero, input int cpi);
        int n;
        bus.op   = op;
        bus.func = func;
        bus.zero = zero;
        model(op, func, zero);
        #1;
        n = 0;
        do begin
            if (n < exp_q.size())
                check($sformatf("%s_cyc%0d", name, n + 1), dut_vec(), exp_q[n]);
            @(negedge clk);
            #1;
            n++;
        end while (bus.state != S_FETCH && n < 8);
        check($sformatf("%s_cpi", name), 20'(n), 20'(cpi));
    endtask

    initial begin
        logic [5:0] rop;
        logic [5:0] rfn;
        logic [5:0] lop[10];
        logic [5:0] lfn[10];
        tbl[0]  = '{"addu",    6'b000000, 6'b100001, 1'b0, 4};
        tbl[1]  = '{"subu",    6'b000000, 6'b100011, 1'b0, 4};
        tbl[2]  = '{"lw",      6'b100011, 6'b000000, 1'b0, 5};
        tbl[3]  = '{"sw",      6'b101011, 6'b010101, 1'b1, 4};
        tbl[4]  = '{"beq_z1",  6'b000100, 6'b000000, 1'b1, 3};
        tbl[5]  = '{"beq_z0",  6'b000100, 6'b000000, 1'b0, 3};
        tbl[6]  = '{"jal",     6'b000011, 6'b000000, 1'b0, 3};
        tbl[7]  = '{"jr",      6'b000000, 6'b001000, 1'b0, 3};
        tbl[8]  = '{"illegal", 6'b111111, 6'b000000, 1'b0, 2};
        tbl[9]  = '{"ori",     6'b001101, 6'b000000, 1'b0, 4};
        tbl[10] = '{"lui",     6'b001111, 6'b000000, 1'b0, 4};
        tbl[11] = '{"j",       6'b000010, 6'b111111, 1'b1, 3};
        lop = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001111,
                6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
        lfn = '{6'b100001, 6'b100011, 6'b001000, 6'b000000, 6'b000000,
                6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};

        bus.op   = 6'b000000;
        bus.func = 6'b000000;
        bus.zero = 1'b0;

        // Reset state: everything quiet, state FETCH
        @(negedge clk);
        #1;
        check("reset", dut_vec(), 20'h00000);
        rst_n = 1'b1;

        foreach (tbl[i])
            run(tbl[i].name, tbl[i].op, tbl[i].func, tbl[i].zero, tbl[i].cpi);

        // Random instruction stream, including arbitrary (mostly illegal) encodings
        for (int k = 0; k < 60; k++) begin
            int r;
            r = $urandom_range(0, 12);
            if (r < 10) begin
                rop = lop[r];
                rfn = (r < 3) ? lfn[r] : 6'($urandom);
            end else begin
                rop = 6'($urandom);
                rfn = 6'($urandom);
            end
            run($sformatf("rnd%0d", k), rop, rfn, 1'($urandom_range(0, 1)),
                cpi_of(classify(rop, rfn)));
        end

        // Reset asserted between edges during the write cycle of a sw
        bus.op   = 6'b101011;
        bus.func = 6'b000000;
        #1;
        check("sw_fetch", {16'h0000, bus.state}, {16'h0000, 4'(S_FETCH)});
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        check("sw_mwr_dmwr", {19'h00000, bus.dmwr}, 20'h00001);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_abort", dut_vec(), 20'h00000);
        @(posedge clk);
        #1;
        check("rst_hold", dut_vec(), 20'h00000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release", dut_vec(), {4'(S_FETCH), 16'b1100_0000_0000_0000});
        @(posedge clk);
        #1;
        check("rst_first_fetch", {16'h0000, bus.state}, {16'h0000, 4'(S_DCD)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
